// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the SP-core register-file writeback path.
// Register-file geometry, writeback requester IDs and the round-robin wrap helper.
package rf_wb_arbiter_pkg;

   localparam int unsigned RF_ADDR_W   = 4;
   localparam int unsigned RF_DATA_W   = 16;
   localparam int unsigned RF_NUM_REGS = 16;
   localparam int unsigned WB_ID_W     = 2;

   typedef enum logic [WB_ID_W-1:0] {
      WB_ALU = 2'd0,
      WB_LSU = 2'd1,
      WB_SFU = 2'd2
   } wb_req_id_e;

   // Requester index following w, wrapping from n-1 back to 0.
   function automatic logic [WB_ID_W-1:0] rr_next(input logic [WB_ID_W-1:0] w,
                                                  input int unsigned        n);
      return ((32'(w) + 32'd1) >= n) ? 2'd0 : (w + 2'd1);
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_picker.sv
// Combinational round-robin win select: scans the valid vector starting at ptr,
// modulo NREQ, and returns the first set index plus an any-valid flag.
module rf_wb_arbiter_rr_picker
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 3
) (
   input  logic [NREQ-1:0]    valid,
   input  logic [WB_ID_W-1:0] ptr,
   output logic [WB_ID_W-1:0] win,
   output logic               any_valid
);

   int unsigned     idx;
   logic [NREQ-1:0] rot;

   // First valid requester at or above ptr, wrapping at NREQ.
   always_comb begin
      win       = '0;
      any_valid = 1'b0;
      idx       = 0;
      rot       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         rot = valid >> idx;
         if (!any_valid && rot[0]) begin
            any_valid = 1'b1;
            win       = WB_ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the SP-core register-file write port.
// Picks one of NREQ requesters per cycle, registers it in a single output stage,
// and drives nD/D/RegWE to the register file. wb_stall holds a full stage.
// Build option: define RF_WB_ARB_RR_EN for round-robin priority; when undefined
// the scan always starts at requester 0 (fixed priority, no rr_ptr state).
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned NREQ   = 3,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned DATA_W = RF_DATA_W
) (
   input  logic                   clk,
   input  logic                   Reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*ADDR_W-1:0] req_reg,
   input  logic [NREQ*DATA_W-1:0] req_data,
   input  logic                   wb_stall,
   output logic [ADDR_W-1:0]      nD,
   output logic [DATA_W-1:0]      D,
   output logic                   RegWE,
   output logic [WB_ID_W-1:0]     grant_id
);

   logic                 out_valid;
   logic [ADDR_W-1:0]    out_reg;
   logic [DATA_W-1:0]    out_data;
   logic [WB_ID_W-1:0]   out_id;

   logic [WB_ID_W-1:0]   scan_ptr;
   logic [WB_ID_W-1:0]   win;
   logic                 any_valid;
   logic                 load_ok;
   logic                 handshake;
   logic [ADDR_W-1:0]    sel_reg;
   logic [DATA_W-1:0]    sel_data;

`ifdef RF_WB_ARB_RR_EN
   logic [WB_ID_W-1:0]   rr_ptr;

   assign scan_ptr = rr_ptr;

   // Priority pointer moves just past each accepted requester; holds when idle.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         rr_ptr <= '0;
      end else if (handshake) begin
         rr_ptr <= rr_next(win, NREQ);
      end
   end
`else
   assign scan_ptr = '0;
`endif

   rf_wb_arbiter_rr_picker #(
      .NREQ (NREQ)
   ) u_picker (
      .valid     (req_valid),
      .ptr       (scan_ptr),
      .win       (win),
      .any_valid (any_valid)
   );

   // Stage accepts when empty or when its current write leaves this cycle.
   always_comb begin
      load_ok   = ~out_valid | ~wb_stall;
      handshake = any_valid & load_ok & ~Reset;
      RegWE     = out_valid & ~wb_stall;
   end

   // Only the winner sees ready; nothing is accepted while reset is asserted.
   always_comb begin
      req_ready = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_ready[i] = any_valid & (win == WB_ID_W'(i)) & load_ok & ~Reset;
      end
   end

   // Select the winner's destination index and data from the packed buses.
   always_comb begin
      sel_reg  = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win == WB_ID_W'(i)) begin
            sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Output stage: load on handshake, empty on an unreplaced drain, else hold.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         out_valid <= 1'b0;
         out_reg   <= '0;
         out_data  <= '0;
         out_id    <= '0;
      end else if (handshake) begin
         out_valid <= 1'b1;
         out_reg   <= sel_reg;
         out_data  <= sel_data;
         out_id    <= win;
      end else if (RegWE) begin
         out_valid <= 1'b0;
      end
   end

   assign nD       = out_reg;
   assign D        = out_data;
   assign grant_id = out_id;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter against a queue-free behavioural model.
// Honors RF_WB_ARB_RR_EN the same way the design does.
module tb_rf_wb_arbiter;
   import rf_wb_arbiter_pkg::*;

   localparam int N   = 3;
   localparam int AW  = 4;
   localparam int DW  = 16;
   localparam int RWT = N*AW;
   localparam int DWT = N*DW;

   logic           clk;
   logic           Reset;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [RWT-1:0] req_reg;
   logic [DWT-1:0] req_data;
   logic           wb_stall;
   logic [AW-1:0]  nD;
   logic [DW-1:0]  D;
   logic           RegWE;
   logic [1:0]     grant_id;

   rf_wb_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .Reset     (Reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_reg   (req_reg),
      .req_data  (req_data),
      .wb_stall  (wb_stall),
      .nD        (nD),
      .D         (D),
      .RegWE     (RegWE),
      .grant_id  (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending write slot, priority start, register-file images.
   int m_ptr   = 0;
   bit m_valid = 0;
   int m_reg   = 0;
   int m_data  = 0;
   int m_id    = 0;
   int rf_exp [RF_NUM_REGS];
   int rf_obs [RF_NUM_REGS];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Winner: first valid requester visiting m_ptr, m_ptr+1, ... modulo N.
   function automatic int m_pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_ptr   = 0;
      m_valid = 0;
      m_reg   = 0;
      m_data  = 0;
      m_id    = 0;
   endtask

   // One cycle: drive at negedge, compare just after, advance model at posedge.
   task automatic step(input logic [N-1:0] v, input logic [RWT-1:0] r,
                       input logic [DWT-1:0] d, input logic st);
      int         w;
      bit         lok;
      bit         we;
      logic [N-1:0] er;
      req_valid = v;
      req_reg   = r;
      req_data  = d;
      wb_stall  = st;
      #1;
      w   = m_pick(v);
      lok = !m_valid || !st;
      we  = m_valid && !st;
      er  = (w >= 0 && lok) ? N'(1 << w) : '0;
      check("ready", 32'(req_ready), 32'(er));
      check("regwe", 32'(RegWE), 32'(we));
      check("nd",    32'(nD), 32'(m_reg));
      check("d",     32'(D), 32'(m_data));
      check("gid",   32'(grant_id), 32'(m_id));
      if (RegWE) rf_obs[nD] = int'(D);
      if (we) rf_exp[m_reg] = m_data;
      @(posedge clk);
      if (w >= 0 && lok) begin
         m_valid = 1;
         m_reg   = int'(r[w*AW +: AW]);
         m_data  = int'(d[w*DW +: DW]);
         m_id    = w;
`ifdef RF_WB_ARB_RR_EN
         m_ptr   = (w + 1) % N;
`endif
      end else if (we) begin
         m_valid = 0;
      end
      @(negedge clk);
   endtask

   // Asynchronous reset from mid-cycle with requests pending.
   task automatic apply_reset();
      req_valid = '1;
      wb_stall  = 1'b0;
      Reset     = 1'b1;
      #1;
      check("rst_regwe", 32'(RegWE), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_nd",    32'(nD), 32'd0);
      check("rst_d",     32'(D), 32'd0);
      check("rst_gid",   32'(grant_id), 32'd0);
      m_reset();
      @(posedge clk);
      @(negedge clk);
      Reset = 1'b0;
   endtask

   task automatic step_rand(input int stall_pct);
      logic [N-1:0]   v;
      logic [RWT-1:0] r;
      logic [DWT-1:0] d;
      logic           st;
      v  = N'($urandom);
      r  = RWT'($urandom);
      d  = DWT'({$urandom, $urandom});
      st = ($urandom_range(99) < 32'(stall_pct));
      step(v, r, d, st);
   endtask

   initial begin
      Reset     = 1'b1;
      req_valid = '0;
      req_reg   = '0;
      req_data  = '0;
      wb_stall  = 1'b0;
      for (int i = 0; i < RF_NUM_REGS; i++) begin
         rf_exp[i] = 0;
         rf_obs[i] = 0;
      end
      @(negedge clk);
      apply_reset();

      // Fill the stage, then reset mid-stream.
      step(3'b111, RWT'($urandom), DWT'({$urandom, $urandom}), 1'b0);
      step(3'b111, RWT'($urandom), DWT'({$urandom, $urandom}), 1'b0);
      apply_reset();

      // Single request from requester 1: reg 5 = 0x1234.
      step(3'b010, {4'd0, 4'd5, 4'd0}, {16'h0, 16'h1234, 16'h0}, 1'b0);
      step(3'b000, '0, '0, 1'b0);

      // All three held valid.
      repeat (6) step(3'b111, RWT'($urandom), DWT'({$urandom, $urandom}), 1'b0);
      step(3'b000, '0, '0, 1'b0);

      // Stall with a write in the stage.
      step(3'b001, {4'd0, 4'd0, 4'd9}, {16'h0, 16'h0, 16'hbeef}, 1'b0);
      repeat (3) step(3'b111, RWT'($urandom), DWT'({$urandom, $urandom}), 1'b1);
      step(3'b010, {4'd0, 4'd3, 4'd0}, {16'h0, 16'h7777, 16'h0}, 1'b0);
      step(3'b000, '0, '0, 1'b0);

      // Same-register race: req0 then req1 to reg 7.
      step(3'b011, {4'd0, 4'd7, 4'd7}, {16'h0, 16'h5555, 16'haaaa}, 1'b0);
      step(3'b010, {4'd0, 4'd7, 4'd7}, {16'h0, 16'h5555, 16'haaaa}, 1'b0);
      step(3'b000, '0, '0, 1'b0);
      check("race_r7", 32'(rf_obs[7]), 32'h5555);

      // Wrap and idle gaps.
      step(3'b010, RWT'($urandom), DWT'({$urandom, $urandom}), 1'b0);
      step(3'b001, RWT'($urandom), DWT'({$urandom, $urandom}), 1'b0);
      step(3'b000, '0, '0, 1'b0);
      step(3'b000, '0, '0, 1'b0);
      step(3'b011, RWT'($urandom), DWT'({$urandom, $urandom}), 1'b0);
      step(3'b000, '0, '0, 1'b0);

      // Requesters 0 and 2 continuously.
      repeat (5) step(3'b101, RWT'($urandom), DWT'({$urandom, $urandom}), 1'b0);
      step(3'b000, '0, '0, 1'b0);

      // Randomized traffic with stalls and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(299) == 0) apply_reset();
         else step_rand(25);
      end
      step(3'b000, '0, '0, 1'b0);
      step(3'b000, '0, '0, 1'b0);

      for (int i = 0; i < RF_NUM_REGS; i++) begin
         check($sformatf("rf%0d", i), 32'(rf_obs[i]), 32'(rf_exp[i]));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
